// File: rtl/spr_pkg.sv
// Shared types and helpers for the parametrised single-port RAM (spr_param).
package spr_pkg;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } spr_state_t;

    // Read latency in cycles for a given output-register setting.
    function automatic int out_lat(input int out_reg);
        return 1 + out_reg;
    endfunction

endpackage

// File: rtl/spr_clear_ctrl.sv
// Sweep controller: state register, clear counter, RDY generation and CLR handling.
module spr_clear_ctrl
    import spr_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              CLR,
    output logic              sweep_we,
    output logic [ADDR_W-1:0] sweep_addr,
    output spr_state_t        state,
    output logic              RDY
);

    logic [ADDR_W-1:0] cnt;

    // RDY is registered alongside the state so it rises on the edge doing the last sweep write.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= S_CLEAR;
            cnt   <= '0;
            RDY   <= 1'b0;
        end else begin
            case (state)
                S_CLEAR: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == '1) begin
                        state <= S_READY;
                        RDY   <= 1'b1;
                    end
                end
                S_READY: begin
                    if (CLR) begin
                        state <= S_CLEAR;
                        cnt   <= '0;
                        RDY   <= 1'b0;
                    end
                end
                default: begin
                    state <= S_CLEAR;
                    cnt   <= '0;
                    RDY   <= 1'b0;
                end
            endcase
        end
    end

    assign sweep_we   = (state == S_CLEAR);
    assign sweep_addr = cnt;

endmodule

// File: rtl/spr_param.sv
// Parametrised single-port synchronous RAM with hardware clear sweep,
// optional output register and read-valid strobe.
module spr_param
    import spr_pkg::*;
#(
    parameter int                DATA_W   = 8,
    parameter int                ADDR_W   = 4,
    parameter int                OUT_REG  = 0,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              CLR,
    input  logic              EN,
    input  logic              WEN,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] Data,
    output logic              RDY,
    output logic [DATA_W-1:0] Q,
    output logic              QV
);

    localparam int DEPTH   = 2 ** ADDR_W;
    localparam int OUT_LAT = out_lat(OUT_REG);

    logic [DATA_W-1:0] mem [DEPTH];
    logic              sweep_we;
    logic [ADDR_W-1:0] sweep_addr;
    spr_state_t        state;
    logic              accept;
    logic              rd;
    logic              wr;

    spr_clear_ctrl #(
        .ADDR_W(ADDR_W)
    ) u_clear_ctrl (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .CLR       (CLR),
        .sweep_we  (sweep_we),
        .sweep_addr(sweep_addr),
        .state     (state),
        .RDY       (RDY)
    );

    // CLR wins over any request presented in the same cycle.
    assign accept = EN && (state == S_READY) && !CLR;
    assign rd     = accept && !WEN;
    assign wr     = accept && WEN;

    // Storage is deliberately not reset; the sweep is what initialises it.
    always_ff @(posedge CLK) begin
        if (sweep_we) begin
            mem[sweep_addr] <= INIT_VAL;
        end else if (wr) begin
            mem[Addr] <= Data;
        end
    end

    generate
        if (OUT_LAT == 2) begin : g_out_reg
            logic [DATA_W-1:0] pipe_q;
            logic              pipe_v;

            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    pipe_q <= '0;
                    pipe_v <= 1'b0;
                    Q      <= '0;
                    QV     <= 1'b0;
                end else begin
                    pipe_v <= rd;
                    if (rd) begin
                        pipe_q <= mem[Addr];
                    end
                    QV <= pipe_v;
                    if (pipe_v) begin
                        Q <= pipe_q;
                    end
                end
            end
        end else begin : g_no_out_reg
            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    Q  <= '0;
                    QV <= 1'b0;
                end else begin
                    QV <= rd;
                    if (rd) begin
                        Q <= mem[Addr];
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_spr_param.sv
// Bench for spr_param: one instance per OUT_REG setting, shared stimulus, checked
// every cycle against a word-level model of the memory, sweep and read latency.
module tb_spr_param;

    localparam logic [7:0] INIT = 8'hA5;
    localparam int         DEPTH = 16;

    logic       CLK;
    logic       RST_N;
    logic       CLR;
    logic       EN;
    logic       WEN;
    logic [3:0] Addr;
    logic [7:0] Data;
    logic       rdy0, rdy1;
    logic [7:0] q0, q1;
    logic       qv0, qv1;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [7:0] mmem [DEPTH];
    bit         mready;
    int         msweep;
    bit         rd_now, rd_prev;
    logic [7:0] rd_now_d, rd_prev_d;
    logic [7:0] exp_q0, exp_q1;
    bit         exp_qv0, exp_qv1;

    spr_param #(
        .DATA_W(8), .ADDR_W(4), .OUT_REG(0), .INIT_VAL(INIT)
    ) dut0 (
        .CLK(CLK), .RST_N(RST_N), .CLR(CLR), .EN(EN), .WEN(WEN),
        .Addr(Addr), .Data(Data), .RDY(rdy0), .Q(q0), .QV(qv0)
    );

    spr_param #(
        .DATA_W(8), .ADDR_W(4), .OUT_REG(1), .INIT_VAL(INIT)
    ) dut1 (
        .CLK(CLK), .RST_N(RST_N), .CLR(CLR), .EN(EN), .WEN(WEN),
        .Addr(Addr), .Data(Data), .RDY(rdy1), .Q(q1), .QV(qv1)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at %0t: observed %h expected %h", tag, $time, obs, exp);
        end
    endtask

    task automatic check_output();
        check("rdy0", {7'b0, rdy0}, {7'b0, mready});
        check("rdy1", {7'b0, rdy1}, {7'b0, mready});
        check("qv0",  {7'b0, qv0},  {7'b0, exp_qv0});
        check("qv1",  {7'b0, qv1},  {7'b0, exp_qv1});
        check("q0", q0, exp_q0);
        check("q1", q1, exp_q1);
    endtask

    task automatic model_reset();
        mready  = 1'b0;
        msweep  = 0;
        rd_now  = 1'b0;
        rd_prev = 1'b0;
        exp_q0  = 8'h00;
        exp_q1  = 8'h00;
        exp_qv0 = 1'b0;
        exp_qv1 = 1'b0;
    endtask

    // One clock edge of behaviour: reads see the memory before this edge's write.
    task automatic model_edge();
        bit         acc;
        logic [7:0] rdval;
        acc       = EN && mready && !CLR;
        rdval     = mmem[Addr];
        rd_prev   = rd_now;
        rd_prev_d = rd_now_d;
        rd_now    = acc && !WEN;
        rd_now_d  = rdval;
        exp_qv0   = rd_now;
        if (rd_now) exp_q0 = rd_now_d;
        exp_qv1   = rd_prev;
        if (rd_prev) exp_q1 = rd_prev_d;
        if (acc && WEN) mmem[Addr] = Data;
        if (!mready) begin
            msweep++;
            if (msweep == DEPTH) begin
                mready = 1'b1;
                for (int i = 0; i < DEPTH; i++) mmem[i] = INIT;
            end
        end else if (CLR) begin
            mready = 1'b0;
            msweep = 0;
        end
    endtask

    task automatic apply_stimulus(input bit en, input bit wen, input logic [3:0] addr,
                                  input logic [7:0] data, input bit clr);
        EN   = en;
        WEN  = wen;
        Addr = addr;
        Data = data;
        CLR  = clr;
        @(posedge CLK);
        model_edge();
        #1;
        check_output();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b0, 4'h0, 8'h00, 1'b0);
    endtask

    task automatic apply_reset();
        RST_N = 1'b0;
        EN    = 1'b0;
        CLR   = 1'b0;
        #1;
        model_reset();
        check_output();
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    initial begin
        RST_N = 1'b0;
        CLR   = 1'b0;
        EN    = 1'b0;
        WEN   = 1'b0;
        Addr  = 4'h0;
        Data  = 8'h00;
        for (int i = 0; i < DEPTH; i++) mmem[i] = 8'h00;
        model_reset();
        #2;
        apply_reset();

        // Writes attempted during the sweep must be ignored.
        for (int i = 0; i < DEPTH; i++) apply_stimulus(1'b1, 1'b1, 4'h3, 8'h3C, 1'b0);

        // Read back every address after the sweep.
        for (int a = 0; a < DEPTH; a++) apply_stimulus(1'b1, 1'b0, 4'(a), 8'h00, 1'b0);
        idle(2);

        // Write then read on the next cycle.
        apply_stimulus(1'b1, 1'b1, 4'h1, 8'h01, 1'b0);
        apply_stimulus(1'b1, 1'b0, 4'h1, 8'h00, 1'b0);
        idle(2);

        // Soft clear with a colliding write.
        apply_stimulus(1'b1, 1'b1, 4'hF, 8'h77, 1'b0);
        apply_stimulus(1'b1, 1'b1, 4'h0, 8'h11, 1'b1);
        idle(DEPTH);
        apply_stimulus(1'b1, 1'b0, 4'hF, 8'h00, 1'b0);
        apply_stimulus(1'b1, 1'b0, 4'h0, 8'h00, 1'b0);
        idle(2);

        // In-flight read across a clear.
        apply_stimulus(1'b1, 1'b1, 4'h2, 8'h22, 1'b0);
        apply_stimulus(1'b1, 1'b0, 4'h2, 8'h00, 1'b0);
        apply_stimulus(1'b0, 1'b0, 4'h0, 8'h00, 1'b1);
        idle(DEPTH + 2);

        // Asynchronous reset between read acceptance and its result.
        apply_stimulus(1'b1, 1'b1, 4'h5, 8'h5A, 1'b0);
        apply_stimulus(1'b1, 1'b0, 4'h5, 8'h00, 1'b0);
        apply_reset();
        idle(DEPTH + 1);
        apply_stimulus(1'b1, 1'b0, 4'h5, 8'h00, 1'b0);
        idle(2);

        // Random traffic with occasional clears.
        for (int i = 0; i < 400; i++) begin
            apply_stimulus(1'($urandom), 1'($urandom), 4'($urandom), 8'($urandom),
                           ($urandom_range(0, 39) == 0));
        end
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
